// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg_pkg;

    // Slot phases: digit lit, then the anti-ghosting guard with all anodes off.
    typedef enum logic {
        StShow  = 1'b0,
        StGuard = 1'b1
    } seg_state_e;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DIGITS = 32;

    // Active-low anodes: all ones means every digit is dark. Slice to NUM_DIGITS at use.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/seg_scan_driver_slot_timer.sv
// Per-digit slot timer: counts SHOW then GUARD cycles and flags the slot's last cycles.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    output seg_state_e state_o,
    output logic       slot_last_o,
    output logic       slot_prelast_o
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CntW-1:0] ShowLastCnt = CntW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] SlotLastCnt = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] PreLastCnt  = CntW'(REFRESH_DIV - 2);

    seg_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            show_last;
    logic            slot_last;

    // Next-state: advance the count, switch phase at the end of SHOW and of GUARD.
    always_comb begin
        show_last = (state_q == StShow) && (cnt_q == ShowLastCnt);
        slot_last = (state_q == StGuard) && (cnt_q == SlotLastCnt);
        cnt_d     = cnt_q + CntW'(1);
        state_d   = state_q;
        if (show_last) begin
            state_d = StGuard;
        end
        if (slot_last) begin
            cnt_d   = '0;
            state_d = StShow;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= StShow;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o        = state_q;
    assign slot_last_o    = slot_last;
    // The count is linear within a slot, so RD-2 always precedes the slot's last cycle.
    assign slot_prelast_o = (cnt_q == PreLastCnt);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous updates
// and leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
    input  logic                           load,
    input  logic                           lz_blank_en,
    output logic [NIBBLE_W-1:0]            digit_nibble,
    output logic [NUM_DIGITS-1:0]          anodes_n,
    output logic                           frame_tick,
    output logic                           busy_pending
);

    localparam int unsigned WordW = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [IdxW-1:0]       LastIdx   = IdxW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AnodesOff = ANODE_OFF[NUM_DIGITS-1:0];

    seg_state_e state;
    logic       slot_last;
    logic       slot_prelast;
    logic       frame_last;

    logic [IdxW-1:0]       idx_q, idx_d;
    logic [WordW-1:0]      display_q, display_d;
    logic [WordW-1:0]      shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  blank_q, blank_d;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic [NIBBLE_W-1:0]   nibble_q, nibble_d;
    logic                  tick_q, tick_d;
    logic                  upper_zero;

    seg_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .state_o        (state),
        .slot_last_o    (slot_last),
        .slot_prelast_o (slot_prelast)
    );

    assign frame_last = slot_last && (idx_q == LastIdx);

    // Next-state for digit index, display/shadow words and the blank decision for the next slot.
    always_comb begin
        idx_d      = idx_q;
        display_d  = display_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        blank_d    = blank_q;
        upper_zero = 1'b1;

        if (slot_last) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
        end

        if (load) begin
            shadow_d = value_in;
        end

        // A load on the boundary cycle bypasses the shadow so it is not delayed a whole frame.
        if (frame_last) begin
            if (load) begin
                display_d = value_in;
            end else if (pending_q) begin
                display_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end

        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if ((IdxW'(k) >= idx_d) && (display_d[k*NIBBLE_W +: NIBBLE_W] != '0)) begin
                upper_zero = 1'b0;
            end
        end

        // Blanking is decided once at SHOW entry so a mid-slot lz_blank_en change cannot flicker.
        if (slot_last) begin
            blank_d = lz_blank_en && (idx_d != '0) && upper_zero;
        end
    end

    // Registered outputs derived from the current slot position.
    always_comb begin
        anodes_d = AnodesOff;
        if ((state == StShow) && !blank_q) begin
            anodes_d[idx_q] = 1'b0;
        end
        nibble_d = display_q[idx_q*NIBBLE_W +: NIBBLE_W];
        // Look one cycle ahead so the pulse lands on the boundary cycle itself.
        tick_d   = slot_prelast && (idx_q == LastIdx);
    end

    // All state and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            display_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            blank_q   <= 1'b0;
            anodes_q  <= AnodesOff;
            nibble_q  <= '0;
            tick_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            display_q <= display_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            blank_q   <= blank_d;
            anodes_q  <= anodes_d;
            nibble_q  <= nibble_d;
            tick_q    <= tick_d;
        end
    end

    assign anodes_n     = anodes_q;
    assign digit_nibble = nibble_q;
    assign frame_tick   = tick_q;
    assign busy_pending = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed table, corner sequences, random vs model.
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        lz = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  digit_nibble;
    logic [3:0]  anodes_n;
    logic        frame_tick;
    logic        busy_pending;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .value_in     (value_in),
        .load         (load),
        .lz_blank_en  (lz),
        .digit_nibble (digit_nibble),
        .anodes_n     (anodes_n),
        .frame_tick   (frame_tick),
        .busy_pending (busy_pending)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: position p within the frame (0..FRAME-1), processed at the next edge.
    int          p = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_sh = 16'h0;
    logic        m_pend = 1'b0;
    logic        m_blank = 1'b0;
    logic [3:0]  e_an;
    logic [3:0]  e_nib;
    logic        e_tick;
    logic        e_busy;

    logic [3:0]  prev_an = 4'hF;
    logic [3:0]  prev_nib = 4'h0;

    int          dig_on[ND];
    logic [15:0] seen;
    int          ticks;
    logic [3:0]  first_an;

    typedef struct {
        int          n;
        logic        ld;
        logic [15:0] v;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        tick;
        logic        busy;
    } row_t;

    row_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic model_step(input logic r, input logic ld, input logic [15:0] v,
                              input logic lzv);
        int         slot;
        int         ph;
        int         nslot;
        logic [3:0] onehot;
        if (!r) begin
            p = 0; m_disp = 16'h0; m_sh = 16'h0; m_pend = 1'b0; m_blank = 1'b0;
            e_an = 4'hF; e_nib = 4'h0; e_tick = 1'b0; e_busy = 1'b0;
            return;
        end
        slot   = (p / RD) % ND;
        ph     = p % RD;
        onehot = 4'b0001 << slot;
        e_an   = ((ph < RD - BC) && !m_blank) ? ~onehot : 4'hF;
        e_nib  = m_disp[4*slot +: 4];
        e_tick = ((p + 1) % FRAME) == (FRAME - 1);
        if (ld) m_sh = v;
        if (p == FRAME - 1) begin
            if (ld) m_disp = v;
            else if (m_pend) m_disp = m_sh;
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        e_busy = m_pend;
        if (ph == RD - 1) begin
            nslot   = (slot + 1) % ND;
            m_blank = lzv && (nslot != 0) && ((m_disp >> (4 * nslot)) == 16'h0);
        end
        p = (p + 1) % FRAME;
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic lzv);
        @(negedge clk);
        rst_n = r; load = ld; value_in = v; lz = lzv;
        model_step(r, ld, v, lzv);
        @(posedge clk);
        #1;
        cyc++;
        chk("anodes_n", anodes_n, e_an);
        chk("digit_nibble", digit_nibble, e_nib);
        chk("frame_tick", frame_tick, e_tick);
        chk("busy_pending", busy_pending, e_busy);
        chk("one_anode_max", $countones(~anodes_n) <= 1, 1'b1);
        if (anodes_n != 4'hF && prev_an != 4'hF) chk("nibble_stable", digit_nibble, prev_nib);
        prev_an  = anodes_n;
        prev_nib = digit_nibble;
    endtask

    task automatic run_frame(input logic lzv);
        seen = 16'h0; ticks = 0;
        for (int d = 0; d < ND; d++) dig_on[d] = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0, lzv);
            if (i == 0) first_an = anodes_n;
            if (frame_tick) ticks++;
            for (int d = 0; d < ND; d++) begin
                if (!anodes_n[d]) begin
                    dig_on[d]++;
                    seen[digit_nibble] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_tick(input logic lzv);
        int n = 0;
        do begin
            step(1'b1, 1'b0, 16'h0, lzv);
            n++;
        end while (!frame_tick && n < 2 * FRAME);
        chk("wait_frame_tick", frame_tick, 1'b1);
    endtask

    initial begin
        logic        r;
        logic        ld;
        logic        lz_cur;
        logic [15:0] v;

        // Reset, then the first two frames with a load at cycle 5.
        tbl.push_back('{4, 1'b0, 16'h0,    4'hE, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b1, 16'h1A2F, 4'hE, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{1, 1'b0, 16'h0,    4'hE, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{2, 1'b0, 16'h0,    4'hF, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{6, 1'b0, 16'h0,    4'hD, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{2, 1'b0, 16'h0,    4'hF, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{6, 1'b0, 16'h0,    4'hB, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{2, 1'b0, 16'h0,    4'hF, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{6, 1'b0, 16'h0,    4'h7, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{1, 1'b0, 16'h0,    4'hF, 4'h0, 1'b1, 1'b1});
        tbl.push_back('{1, 1'b0, 16'h0,    4'hF, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{6, 1'b0, 16'h0,    4'hE, 4'hF, 1'b0, 1'b0});
        tbl.push_back('{2, 1'b0, 16'h0,    4'hF, 4'hF, 1'b0, 1'b0});
        tbl.push_back('{6, 1'b0, 16'h0,    4'hD, 4'h2, 1'b0, 1'b0});
        tbl.push_back('{2, 1'b0, 16'h0,    4'hF, 4'h2, 1'b0, 1'b0});
        tbl.push_back('{6, 1'b0, 16'h0,    4'hB, 4'hA, 1'b0, 1'b0});
        tbl.push_back('{2, 1'b0, 16'h0,    4'hF, 4'hA, 1'b0, 1'b0});
        tbl.push_back('{6, 1'b0, 16'h0,    4'h7, 4'h1, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b0, 16'h0,    4'hF, 4'h1, 1'b1, 1'b0});
        tbl.push_back('{1, 1'b0, 16'h0,    4'hF, 4'h1, 1'b0, 1'b0});

        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("reset_anodes", anodes_n, 4'hF);
        chk("reset_busy", busy_pending, 1'b0);

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                step(1'b1, tbl[i].ld, tbl[i].v, 1'b0);
                chk("tbl_anodes", anodes_n, tbl[i].an);
                chk("tbl_nibble", digit_nibble, tbl[i].nib);
                chk("tbl_tick", frame_tick, tbl[i].tick);
                chk("tbl_busy", busy_pending, tbl[i].busy);
            end
        end

        // Two loads in one frame: the second wins, the first never shows.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h1111, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h2222, 1'b0);
        chk("two_loads_busy", busy_pending, 1'b1);
        for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        run_frame(1'b0);
        chk("two_loads_seen", seen, 16'h0004);
        chk("two_loads_ticks", ticks, 1);

        // Load exactly on the boundary with leading-zero blanking.
        wait_tick(1'b1);
        step(1'b1, 1'b1, 16'h00B0, 1'b1);
        chk("bypass_busy", busy_pending, 1'b0);
        run_frame(1'b1);
        chk("lz_dig0_on", dig_on[0], 6);
        chk("lz_dig1_on", dig_on[1], 6);
        chk("lz_dig2_on", dig_on[2], 0);
        chk("lz_dig3_on", dig_on[3], 0);
        chk("lz_seen", seen, 16'h0801);
        chk("lz_ticks", ticks, 1);

        // All-zero value with blanking: only digit 0 lights.
        step(1'b1, 1'b1, 16'h0000, 1'b1);
        chk("zero_busy", busy_pending, 1'b1);
        wait_tick(1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        run_frame(1'b1);
        chk("zero_dig0_on", dig_on[0], 6);
        chk("zero_dig123_on", dig_on[1] + dig_on[2] + dig_on[3], 0);
        chk("zero_seen", seen, 16'h0001);

        // Reset mid-SHOW of digit 2 with a pending value.
        step(1'b1, 1'b1, 16'h5678, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("pend_before_rst", busy_pending, 1'b1);
        chk("dig2_before_rst", anodes_n, 4'hB);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("rst_anodes", anodes_n, 4'hF);
        chk("rst_busy", busy_pending, 1'b0);
        run_frame(1'b0);
        chk("restart_digit0", first_an, 4'hE);
        chk("rst_frame1_seen", seen, 16'h0001);
        run_frame(1'b0);
        chk("rst_frame2_seen", seen, 16'h0001);
        chk("rst_frame2_dig3", dig_on[3], 6);

        // Randomized traffic against the model.
        lz_cur = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 599) != 0);
            ld = (p == FRAME - 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 4; k++) begin
                v[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if ($urandom_range(0, 63) == 0) lz_cur = ~lz_cur;
            step(r, ld, v, lz_cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
